// File: rtl/mux_n_1_pipe.sv
// N-input, W-bit multiplexer with a registered output behind a 2-entry skid buffer.
// Optional illegal-select counter (err_count port) is enabled by defining MUX_ERR_CNT_EN.
`timescale 1ns/1ps

module mux_n_1_pipe #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
    output logic                    out_valid,
`ifdef MUX_ERR_CNT_EN
    output logic [7:0]              err_count,
`endif
    input  logic                    out_ready
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             head_err_q, head_err_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q, skid_err_d;
    logic             in_ready_q, in_ready_d;

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             acc;
    logic             dlv;

    // Matching sel against each legal index avoids a constant compare when NUM_IN is a power of two.
    always_comb begin
        sel_data = '0;
        sel_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = in_bus[k*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    assign acc = in_valid && in_ready_q;
    assign dlv = (state_q != ST_EMPTY) && out_ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_err_d  = head_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d     = ST_ONE;
                    head_data_d = sel_data;
                    head_err_d  = sel_err;
                end
            end
            ST_ONE: begin
                if (acc && !dlv) begin
                    state_d     = ST_TWO;
                    skid_data_d = sel_data;
                    skid_err_d  = sel_err;
                end else if (!acc && dlv) begin
                    state_d     = ST_EMPTY;
                end else if (acc && dlv) begin
                    head_data_d = sel_data;
                    head_err_d  = sel_err;
                end
            end
            ST_TWO: begin
                if (dlv) begin
                    state_d     = ST_ONE;
                    head_data_d = skid_data_q;
                    head_err_d  = skid_err_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            head_data_q <= '0;
            head_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_err_q  <= head_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            in_ready_q  <= in_ready_d;
        end
    end

`ifdef MUX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (acc && sel_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_data    = head_data_q;
    assign out_sel_err = head_err_q;

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Self-checking bench for mux_n_1_pipe: three instances (5b/4-in, 5b/3-in, 8b/16-in) with per-instance scoreboards.
`timescale 1ns/1ps

module tb_mux_n_1_pipe;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic [19:0]  a_in_bus;
    logic [1:0]   a_sel;
    logic         a_in_valid, a_in_ready, a_out_sel_err, a_out_valid, a_out_ready;
    logic [4:0]   a_out_data;

    logic [14:0]  b_in_bus;
    logic [1:0]   b_sel;
    logic         b_in_valid, b_in_ready, b_out_sel_err, b_out_valid, b_out_ready;
    logic [4:0]   b_out_data;

    logic [127:0] c_in_bus;
    logic [3:0]   c_sel;
    logic         c_in_valid, c_in_ready, c_out_sel_err, c_out_valid, c_out_ready;
    logic [7:0]   c_out_data;

`ifdef MUX_ERR_CNT_EN
    logic [7:0]   a_err_count, b_err_count, c_err_count;
`endif

    int n_vectors     = 0;
    int n_miscompares = 0;

    logic [8:0] q_a[$];
    logic [8:0] q_b[$];
    logic [8:0] q_c[$];
    int a_delivered = 0;
    int c_delivered = 0;
    int c_pushed    = 0;

    mux_n_1_pipe #(.WIDTH(5), .NUM_IN(4)) u_a (
        .clk(clk), .reset(reset), .in_bus(a_in_bus), .sel(a_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_sel_err(a_out_sel_err), .out_valid(a_out_valid),
`ifdef MUX_ERR_CNT_EN
        .err_count(a_err_count),
`endif
        .out_ready(a_out_ready)
    );

    mux_n_1_pipe #(.WIDTH(5), .NUM_IN(3)) u_b (
        .clk(clk), .reset(reset), .in_bus(b_in_bus), .sel(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_sel_err(b_out_sel_err), .out_valid(b_out_valid),
`ifdef MUX_ERR_CNT_EN
        .err_count(b_err_count),
`endif
        .out_ready(b_out_ready)
    );

    mux_n_1_pipe #(.WIDTH(8), .NUM_IN(16)) u_c (
        .clk(clk), .reset(reset), .in_bus(c_in_bus), .sel(c_sel),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
        .out_sel_err(c_out_sel_err), .out_valid(c_out_valid),
`ifdef MUX_ERR_CNT_EN
        .err_count(c_err_count),
`endif
        .out_ready(c_out_ready)
    );

    // Reference selection: bit 8 is the illegal-select flag, bits 7:0 the selected word.
    function automatic logic [8:0] model(input logic [127:0] bus, input int s, input int width, input int num);
        logic [127:0] shifted;
        if (s >= num) return 9'h100;
        shifted = bus >> (s * width);
        return {1'b0, shifted[7:0] & 8'((9'd1 << width) - 9'd1)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one word on instance a (chan 0) or b (chan 1) and wait, bounded, until it is accepted.
    task automatic applyStimulus(input int chan, input int s, input int max_cycles);
        bit took;
        took = 1'b0;
        if (chan == 0) begin a_sel = 2'(s); a_in_valid = 1'b1; end
        else           begin b_sel = 2'(s); b_in_valid = 1'b1; end
        for (int i = 0; i < max_cycles && !took; i++) begin
            took = (chan == 0) ? a_in_ready : b_in_ready;
            @(posedge clk); #1;
        end
        checkOutput($sformatf("accept_ch%0d_sel%0d", chan, s), 32'(took), 32'd1);
        if (chan == 0) a_in_valid = 1'b0;
        else           b_in_valid = 1'b0;
    endtask

    task automatic drain(input int chan);
        logic v;
        v = (chan == 0) ? a_out_valid : (chan == 1) ? b_out_valid : c_out_valid;
        for (int i = 0; i < 20 && v; i++) begin
            @(posedge clk); #1;
            v = (chan == 0) ? a_out_valid : (chan == 1) ? b_out_valid : c_out_valid;
        end
        checkOutput($sformatf("drained_ch%0d", chan), 32'(v), 32'd0);
    endtask

    // Scoreboards sample at the falling edge, i.e. the values the next rising edge will act on.
    always @(negedge clk) begin
        logic [8:0] e;
        if (reset) begin
            q_a.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                checkOutput("a_q_nonempty", 32'(q_a.size() != 0), 32'd1);
                if (q_a.size() != 0) begin
                    e = q_a.pop_front();
                    checkOutput("a_data", 32'(a_out_data), 32'(e[7:0]));
                    checkOutput("a_err", 32'(a_out_sel_err), 32'(e[8]));
                    a_delivered++;
                end
            end
            if (a_in_valid && a_in_ready) q_a.push_back(model(128'(a_in_bus), int'(a_sel), 5, 4));
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (reset) begin
            q_b.delete();
        end else begin
            if (b_out_valid && b_out_ready) begin
                checkOutput("b_q_nonempty", 32'(q_b.size() != 0), 32'd1);
                if (q_b.size() != 0) begin
                    e = q_b.pop_front();
                    checkOutput("b_data", 32'(b_out_data), 32'(e[7:0]));
                    checkOutput("b_err", 32'(b_out_sel_err), 32'(e[8]));
                end
            end
            if (b_in_valid && b_in_ready) q_b.push_back(model(128'(b_in_bus), int'(b_sel), 5, 3));
        end
    end

    logic c_prev_valid = 1'b0, c_prev_ready = 1'b0, c_prev_reset = 1'b1;

    always @(negedge clk) begin
        logic [8:0] e;
        if (reset) begin
            q_c.delete();
        end else begin
            if (c_prev_valid && !c_prev_ready && !c_prev_reset)
                checkOutput("c_valid_hold", 32'(c_out_valid), 32'd1);
            if (c_out_valid && c_out_ready) begin
                checkOutput("c_q_nonempty", 32'(q_c.size() != 0), 32'd1);
                if (q_c.size() != 0) begin
                    e = q_c.pop_front();
                    checkOutput("c_data", 32'(c_out_data), 32'(e[7:0]));
                    checkOutput("c_err", 32'(c_out_sel_err), 32'(e[8]));
                    c_delivered++;
                end
            end
            if (c_in_valid && c_in_ready) begin
                q_c.push_back(model(c_in_bus, int'(c_sel), 8, 16));
                c_pushed++;
            end
        end
        c_prev_valid = c_out_valid;
        c_prev_ready = c_out_ready;
        c_prev_reset = reset;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [4:0] stream_exp [4];
        bit         last_took;
        stream_exp = '{5'd12, 5'd3, 5'd7, 5'd31};

        reset = 1'b1;
        a_in_bus = '0; a_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        b_in_bus = '0; b_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        c_in_bus = '0; c_sel = '0; c_in_valid = 1'b0; c_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(a_in_ready), 32'd1);
        checkOutput("rst_out_data", 32'(a_out_data), 32'd0);
        checkOutput("rst_out_sel_err", 32'(a_out_sel_err), 32'd0);
`ifdef MUX_ERR_CNT_EN
        checkOutput("rst_err_count", 32'(a_err_count), 32'd0);
`endif
        reset = 1'b0;

        $display("[TB] streaming");
        a_in_bus = {5'd31, 5'd7, 5'd3, 5'd12};
        a_out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            applyStimulus(0, s, 4);
            checkOutput($sformatf("stream_valid_%0d", s), 32'(a_out_valid), 32'd1);
            checkOutput($sformatf("stream_data_%0d", s), 32'(a_out_data), 32'(stream_exp[s]));
            checkOutput($sformatf("stream_ready_%0d", s), 32'(a_in_ready), 32'd1);
        end
        @(posedge clk); #1;
        checkOutput("stream_empty", 32'(a_out_valid), 32'd0);

        $display("[TB] backpressure");
        a_out_ready = 1'b0;
        applyStimulus(0, 1, 4);
        applyStimulus(0, 2, 4);
        checkOutput("bp_ready_low", 32'(a_in_ready), 32'd0);
        a_sel = 2'd3;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_still_low", 32'(a_in_ready), 32'd0);
        checkOutput("bp_head_held", 32'(a_out_data), 32'd3);
        a_out_ready = 1'b1;
        applyStimulus(0, 3, 10);
        drain(0);
        checkOutput("bp_delivered", 32'(a_delivered), 32'd7);
        checkOutput("bp_q_empty", 32'(q_a.size()), 32'd0);

        $display("[TB] reset mid-operation");
        a_out_ready = 1'b0;
        applyStimulus(0, 0, 4);
        applyStimulus(0, 1, 4);
        checkOutput("mid_two_ready", 32'(a_in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("mid_rst_valid", 32'(a_out_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(a_in_ready), 32'd1);
        a_out_ready = 1'b1;
        applyStimulus(0, 2, 4);
        checkOutput("mid_new_valid", 32'(a_out_valid), 32'd1);
        checkOutput("mid_new_data", 32'(a_out_data), 32'd7);
        drain(0);
        checkOutput("mid_q_empty", 32'(q_a.size()), 32'd0);

        $display("[TB] illegal select");
        b_in_bus = {5'd9, 5'd6, 5'd21};
        b_out_ready = 1'b1;
        applyStimulus(1, 3, 4);
        checkOutput("ill_data", 32'(b_out_data), 32'd0);
        checkOutput("ill_err", 32'(b_out_sel_err), 32'd1);
`ifdef MUX_ERR_CNT_EN
        checkOutput("ill_cnt_1", 32'(b_err_count), 32'd1);
`endif
        applyStimulus(1, 2, 4);
        checkOutput("legal_top_data", 32'(b_out_data), 32'd9);
        checkOutput("legal_top_err", 32'(b_out_sel_err), 32'd0);
`ifdef MUX_ERR_CNT_EN
        checkOutput("legal_cnt_keep", 32'(b_err_count), 32'd1);
`endif
        for (int i = 0; i < 300; i++) applyStimulus(1, 3, 4);
`ifdef MUX_ERR_CNT_EN
        checkOutput("ill_cnt_sat", 32'(b_err_count), 32'd255);
`endif
        drain(1);
        checkOutput("ill_q_empty", 32'(q_b.size()), 32'd0);

        $display("[TB] random valid/ready");
        last_took = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (!c_in_valid || last_took) begin
                c_in_valid = ($urandom_range(0, 3) != 0);
                for (int j = 0; j < 4; j++) c_in_bus[j*32 +: 32] = $urandom;
                c_sel = 4'($urandom_range(0, 15));
            end
            c_out_ready = ($urandom_range(0, 2) != 0);
            last_took = c_in_valid && c_in_ready;
            @(posedge clk); #1;
        end
        c_in_valid = 1'b0;
        c_out_ready = 1'b1;
        drain(2);
        checkOutput("rnd_q_empty", 32'(q_c.size()), 32'd0);
        checkOutput("rnd_count", 32'(c_delivered), 32'(c_pushed));

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
